// File: rtl/aes_pkg.sv
// Shared AES widths, round counts, controller state encoding and GF(2^8) helpers
// used by the inverse-cipher controller and its round datapath.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NR_128      = 10;
    localparam int NR_192      = 12;
    localparam int NR_256      = 14;
    localparam int RND_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/inv_round_dp.sv
// Combinational single inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round is set. No state, no handshake.
module inv_round_dp
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] round_key,
    input  logic                   last_round,
    output logic [AES_BLOCK_W-1:0] next_state
);

    logic [7:0] ak [16];
    logic [7:0] mc [16];

    // Byte i sits at row i%4, column i/4; row r is rotated right by r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = R + 4 * ((C + 4 - R) % 4);

        assign ak[i] = inv_sbox(state[127 - 8*SRC -: 8]) ^ round_key[127 - 8*i -: 8];
        assign next_state[127 - 8*i -: 8] = last_round ? ak[i] : mc[i];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mc[4*c+0] = gf_mul(ak[4*c+0], 8'h0e) ^ gf_mul(ak[4*c+1], 8'h0b)
                         ^ gf_mul(ak[4*c+2], 8'h0d) ^ gf_mul(ak[4*c+3], 8'h09);
        assign mc[4*c+1] = gf_mul(ak[4*c+0], 8'h09) ^ gf_mul(ak[4*c+1], 8'h0e)
                         ^ gf_mul(ak[4*c+2], 8'h0b) ^ gf_mul(ak[4*c+3], 8'h0d);
        assign mc[4*c+2] = gf_mul(ak[4*c+0], 8'h0d) ^ gf_mul(ak[4*c+1], 8'h09)
                         ^ gf_mul(ak[4*c+2], 8'h0e) ^ gf_mul(ak[4*c+3], 8'h0b);
        assign mc[4*c+3] = gf_mul(ak[4*c+0], 8'h0b) ^ gf_mul(ak[4*c+1], 8'h0d)
                         ^ gf_mul(ak[4*c+2], 8'h09) ^ gf_mul(ak[4*c+3], 8'h0e);
    end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES inverse cipher: out_valid rises NR cycles after acceptance.
// Holds DONE with stable out_data while out_ready is low; in_ready only in IDLE.
module inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic [RND_W-1:0]       round_idx,
    input  logic [AES_BLOCK_W-1:0] round_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam logic [RND_W-1:0] RND_IDLE  = RND_W'(NR);
    localparam logic [RND_W-1:0] RND_FIRST = RND_W'(NR - 1);

    fsm_t                   fsm;
    logic [RND_W-1:0]       rnd;
    logic [AES_BLOCK_W-1:0] blk_state;
    logic [AES_BLOCK_W-1:0] dp_out;
    logic                   last_round;

    assign last_round = (fsm == FINAL);
    assign out_data   = blk_state;

    inv_round_dp u_dp (
        .state      (blk_state),
        .round_key  (round_key),
        .last_round (last_round),
        .next_state (dp_out)
    );

    // round_idx is registered from the next state so the key store sees it
    // at the start of the cycle that consumes the key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            blk_state <= '0;
            rnd       <= RND_FIRST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            round_idx <= RND_IDLE;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        blk_state <= in_data ^ round_key;
                        rnd       <= RND_FIRST;
                        fsm       <= ROUND;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        round_idx <= RND_FIRST;
                    end
                end
                ROUND: begin
                    blk_state <= dp_out;
                    if (rnd == 4'd1) begin
                        fsm       <= FINAL;
                        round_idx <= '0;
                    end else begin
                        rnd       <= rnd - 4'd1;
                        round_idx <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    blk_state <= dp_out;
                    fsm       <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        round_idx <= RND_IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: NR=10 and NR=14 instances against FIPS-197 vectors
// and a table-based textbook inverse-cipher model with random keys and ciphertexts.
module tb_inv_cipher_ctrl;
    import aes_pkg::*;

    typedef struct {
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
    } vec_t;

    localparam logic [255:0] C1_KEY  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, round_key, out_data;
    logic [3:0]   round_idx;
    logic         in_valid_14, in_ready_14, out_valid_14, out_ready_14, busy_14;
    logic [127:0] in_data_14, round_key_14, out_data_14;
    logic [3:0]   round_idx_14;

    logic [127:0] ks10   [0:15];
    logic [127:0] ks14   [0:15];
    logic [127:0] ks_tmp [0:15];
    logic [7:0]   sbox   [256];
    logic [7:0]   isbox  [256];
    int checks   = 0;
    int failures = 0;

    assign round_key    = ks10[round_idx];
    assign round_key_14 = ks14[round_idx_14];

    inv_cipher_ctrl #(.NR(NR_128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .round_idx(round_idx), .round_key(round_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    inv_cipher_ctrl #(.NR(NR_256)) dut_14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_14), .in_ready(in_ready_14),
        .in_data(in_data_14), .round_idx(round_idx_14), .round_key(round_key_14),
        .out_valid(out_valid_14), .out_ready(out_ready_14), .out_data(out_data_14),
        .busy(busy_14)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box by brute-force inversion plus affine map; inverse by table lookup.
    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        case (nr)
            NR_128:  nk = 4;
            NR_192:  nk = 6;
            default: nk = 8;
        endcase
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) ks_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher on a 4x4 state matrix, keys from ks_tmp.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4];
        logic [127:0] res;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = ct[127 - 8*(r+4*c) -: 8] ^ ks_tmp[nr][127 - 8*(r+4*c) -: 8];
        for (int rd = nr - 1; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isbox[s[r][(c - r + 4) % 4]] ^ ks_tmp[rd][127 - 8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rd > 0) begin
                        s[r][c] = 8'h00;
                        for (int k = 0; k < 4; k++) s[r][c] = s[r][c] ^ gmul(m[(k - r + 4) % 4], t[k][c]);
                    end else begin
                        s[r][c] = t[r][c];
                    end
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[127 - 8*(r+4*c) -: 8] = s[r][c];
        return res;
    endfunction

    // Starts and ends just after a falling edge with the NR=10 DUT in IDLE.
    task automatic run10(input vec_t v, input string nm);
        int lat;
        expand_key(v.key, NR_128);
        ks10 = ks_tmp;
        chk_i({nm, "_idle_rdy"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = v.ct;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_i({nm, "_latency"}, lat, NR_128);
        for (int h = 0; h < v.hold; h++) begin
            chk_i({nm, "_hold_vld"}, int'(out_valid), 1);
            chk({nm, "_hold_dat"}, out_data, v.pt);
            chk_i({nm, "_hold_rdy"}, int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk({nm, "_data"}, out_data, v.pt);
        chk_i({nm, "_busy"}, int'(busy), 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk_i({nm, "_rel_rdy"}, int'(in_ready), 1);
        chk_i({nm, "_rel_vld"}, int'(out_valid), 0);
        chk_i({nm, "_rel_idx"}, int'(round_idx), NR_128);
    endtask

    task automatic run14(input logic [255:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input string nm);
        int lat;
        bit seq_ok;
        expand_key(key, NR_256);
        ks14 = ks_tmp;
        chk_i({nm, "_idle_idx"}, int'(round_idx_14), NR_256);
        in_valid_14 = 1'b1;
        in_data_14  = ct;
        @(negedge clk);
        in_valid_14 = 1'b0;
        lat = 0;
        seq_ok = 1'b1;
        while (out_valid_14 !== 1'b1 && lat < 40) begin
            if (int'(round_idx_14) != ((lat < NR_256 - 1) ? NR_256 - 1 - lat : 0)) seq_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk_i({nm, "_idx_seq"}, int'(seq_ok), 1);
        chk_i({nm, "_latency"}, lat, NR_256);
        chk({nm, "_data"}, out_data_14, pt);
        out_ready_14 = 1'b1;
        @(negedge clk);
        out_ready_14 = 1'b0;
        chk_i({nm, "_rel_rdy"}, int'(in_ready_14), 1);
    endtask

    initial begin
        vec_t         vecs [8];
        logic [255:0] k14;
        logic [127:0] ct2, pt2;
        int           lat, cyc, nacc, nres;
        int           acc [2];
        bit           ok;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid_14 = 1'b0; in_data_14 = '0; out_ready_14 = 1'b0;
        build_tables();

        vecs[0] = '{C1_KEY, C1_CT, FIPS_PT, 0};
        vecs[1] = '{C1_KEY, C1_CT, FIPS_PT, 5};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vecs[i].ct   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].hold = int'($urandom_range(0, 3));
            expand_key(vecs[i].key, NR_128);
            vecs[i].pt = ref_decrypt(vecs[i].ct, NR_128);
        end

        repeat (2) @(negedge clk);
        chk_i("rst_in_ready", int'(in_ready), 1);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_round_idx", int'(round_idx), NR_128);
        chk("rst_out_data", out_data, 128'h0);
        chk_i("rst_round_idx_14", int'(round_idx_14), NR_256);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run10(vecs[i], $sformatf("vec%0d", i));

        // Second ciphertext held on in_valid while the first is in flight.
        ct2 = {$urandom, $urandom, $urandom, $urandom};
        expand_key(C1_KEY, NR_128);
        pt2 = ref_decrypt(ct2, NR_128);
        ks10 = ks_tmp;
        in_valid = 1'b1;
        in_data = C1_CT;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = ct2;
        ok = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk_i("busy_rej_rdy_low", int'(ok), 1);
        chk_i("busy_rej_rdy_done", int'(in_ready), 0);
        chk("busy_rej_first", out_data, FIPS_PT);
        @(negedge clk);
        chk_i("busy_rej_accept_rdy", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_rej_second", out_data, pt2);
        @(negedge clk);
        out_ready = 1'b0;

        // Back-to-back C.1 blocks with the sink always ready.
        cyc = 0; nacc = 0; nres = 0;
        acc[0] = 0; acc[1] = 0;
        in_valid = 1'b1;
        in_data = C1_CT;
        out_ready = 1'b1;
        while (nres < 2 && cyc < 60) begin
            if (in_valid && in_ready === 1'b1 && nacc < 2) begin
                acc[nacc] = cyc;
                nacc++;
            end
            if (out_valid === 1'b1) begin
                chk("b2b_data", out_data, FIPS_PT);
                nres++;
            end
            @(negedge clk);
            cyc++;
            if (nacc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk_i("b2b_results", nres, 2);
        chk_i("b2b_spacing", acc[1] - acc[0], NR_128 + 2);
        @(negedge clk);

        // Reset in the middle of the rounds.
        in_valid = 1'b1;
        in_data = C1_CT;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_i("midrst_in_ready", int'(in_ready), 1);
        chk_i("midrst_out_valid", int'(out_valid), 0);
        chk_i("midrst_round_idx", int'(round_idx), NR_128);
        chk_i("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk_i("midrst_no_output", int'(ok), 1);
        run10(vecs[0], "post_rst");

        run14(C3_KEY, C3_CT, FIPS_PT, "c3");
        k14 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ct2 = {$urandom, $urandom, $urandom, $urandom};
        expand_key(k14, NR_256);
        pt2 = ref_decrypt(ct2, NR_256);
        run14(k14, ct2, pt2, "rnd14");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
